// File: rtl/register_file_nr.sv
// Parametrised register file: DEPTH words of WIDTH bits, one synchronous write
// port, two combinational read ports, optional write-to-read bypass.
module register_file_nr #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned BYPASS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr0,
  output logic [WIDTH-1:0] rd_data0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  output logic             wr_err
);

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_err_q, wr_err_d;
  logic             wr_in_range;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    wr_err_d    = we && !wr_in_range;
    mem_d       = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we && wr_in_range && (wr_addr == AW'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Decoding only the DEPTH valid addresses makes out-of-range reads return 0.
  always_comb begin
    rd_data0 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr0 == AW'(i)) rd_data0 = mem_q[i];
    end
    if ((BYPASS != 0) && we && wr_in_range && (rd_addr0 == wr_addr)) begin
      rd_data0 = wr_data;
    end
  end

  always_comb begin
    rd_data1 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr1 == AW'(i)) rd_data1 = mem_q[i];
    end
    if ((BYPASS != 0) && we && wr_in_range && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_register_file_nr.sv
// Bench for register_file_nr: three instances (BYPASS=0, BYPASS=1, DEPTH=6)
// driven from shared inputs and checked against an array-based model.
`timescale 1ns/100ps
module tb_register_file_nr;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  wr_addr, rd_addr0, rd_addr1;
  logic [31:0] wr_data;
  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1, c_rd0, c_rd1;
  logic        a_err, b_err, c_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_file_nr #(.WIDTH(32), .DEPTH(8), .AW(3), .BYPASS(0)) u_a (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(a_rd0), .rd_addr1(rd_addr1), .rd_data1(a_rd1),
    .wr_err(a_err));

  register_file_nr #(.WIDTH(32), .DEPTH(8), .AW(3), .BYPASS(1)) u_b (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(b_rd0), .rd_addr1(rd_addr1), .rd_data1(b_rd1),
    .wr_err(b_err));

  register_file_nr #(.WIDTH(32), .DEPTH(6), .AW(3), .BYPASS(0)) u_c (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(c_rd0), .rd_addr1(rd_addr1), .rd_data1(c_rd1),
    .wr_err(c_err));

  // Reference model: plain arrays per instance.
  int unsigned m_depth [3] = '{8, 8, 6};
  bit          m_byp   [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] m_mem   [3][8];
  logic        m_err   [3];

  function automatic logic [31:0] model_rd(int k, logic [2:0] a);
    if (int'(a) >= int'(m_depth[k])) return 32'h0;
    if (m_byp[k] && we && wr_addr == a && int'(wr_addr) < int'(m_depth[k])) return wr_data;
    return m_mem[k][a];
  endfunction

  function automatic logic [31:0] dut_rd(int k, int port);
    case (k)
      0:       return port == 0 ? a_rd0 : a_rd1;
      1:       return port == 0 ? b_rd0 : b_rd1;
      default: return port == 0 ? c_rd0 : c_rd1;
    endcase
  endfunction

  function automatic logic dut_err(int k);
    case (k)
      0:       return a_err;
      1:       return b_err;
      default: return c_err;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = 32'h0;
      m_err[k] = 1'b0;
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.inst%0d.rd0", tag, k), dut_rd(k, 0), model_rd(k, rd_addr0));
      chk($sformatf("%s.inst%0d.rd1", tag, k), dut_rd(k, 1), model_rd(k, rd_addr1));
      chk($sformatf("%s.inst%0d.err", tag, k), {31'h0, dut_err(k)}, {31'h0, m_err[k]});
    end
  endtask

  // Advance one rising edge, update the model, then settle 1 ns.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        m_err[k] = we && (int'(wr_addr) >= int'(m_depth[k]));
        if (we && int'(wr_addr) < int'(m_depth[k])) m_mem[k][wr_addr] = wr_data;
      end
    end
    #1;
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_before_a;
    logic [31:0] exp_before_b;
    logic [31:0] exp_after_a;
  } wr_vec_t;

  typedef struct {
    logic [2:0]  rd0;
    logic [2:0]  rd1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } rd_vec_t;

  wr_vec_t wv [8];
  rd_vec_t rv [8];
  logic [31:0] sweep [8] = '{32'h12345678, 32'h98765432, 32'hffeeddcc, 32'hbbaabbaa,
                             32'h77665544, 32'h33221100, 32'h00000000, 32'hffffffff};

  initial begin
    for (int i = 0; i < 8; i++) begin
      wv[i] = '{addr: 3'(i), data: sweep[i], exp_before_a: 32'h0,
                exp_before_b: sweep[i], exp_after_a: sweep[i]};
      rv[i] = '{rd0: 3'(i), rd1: 3'(7 - i), exp0: sweep[i], exp1: sweep[7 - i]};
    end

    // Reset held for 7 ns, released between edges.
    reset = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;
    model_clear();
    #2;
    check_all("reset_held");
    #5 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr0 = 3'(i); rd_addr1 = 3'(7 - i);
      #0.5;
      chk("reset_rd0", a_rd0, 32'h0);
      chk("reset_rd1", a_rd1, 32'h0);
      chk("reset_err", {31'h0, a_err}, 32'h0);
    end

    // Write sweep: data must not appear on u_a before its edge.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wr_addr = wv[i].addr; wr_data = wv[i].data;
      rd_addr0 = wv[i].addr; rd_addr1 = 3'((i + 7) % 8);
      #1;
      chk("sweep_before_a", a_rd0, wv[i].exp_before_a);
      chk("sweep_before_b", b_rd0, wv[i].exp_before_b);
      check_all("sweep_pre");
      tick();
      we = 1'b0;
      #0.5;
      chk("sweep_after_a", a_rd0, wv[i].exp_after_a);
      check_all("sweep_post");
    end

    for (int i = 0; i < 8; i++) begin
      rd_addr0 = rv[i].rd0; rd_addr1 = rv[i].rd1;
      #0.5;
      chk("read_a0", a_rd0, rv[i].exp0);
      chk("read_a1", a_rd1, rv[i].exp1);
      chk("read_b0", b_rd0, rv[i].exp0);
      chk("read_b1", b_rd1, rv[i].exp1);
      check_all("read");
    end

    // Read-during-write to word 3 (holds bbaabbaa from the sweep).
    tick();
    we = 1'b1; wr_addr = 3'd3; wr_data = 32'hdeadbeef; rd_addr0 = 3'd3; rd_addr1 = 3'd2;
    #1;
    chk("rdw_a_before", a_rd0, 32'hbbaabbaa);
    chk("rdw_b_before", b_rd0, 32'hdeadbeef);
    chk("rdw_b_port1", b_rd1, 32'hffeeddcc);
    check_all("rdw_pre");
    tick();
    we = 1'b0;
    #0.5;
    chk("rdw_a_after", a_rd0, 32'hdeadbeef);
    check_all("rdw_post");

    // Out-of-range writes on the DEPTH=6 instance: two bad writes then idle.
    we = 1'b1; wr_addr = 3'd6; wr_data = 32'hcafef00d; rd_addr0 = 3'd6; rd_addr1 = 3'd7;
    tick();
    chk("oor_err1", {31'h0, c_err}, 32'h1);
    check_all("oor1");
    wr_addr = 3'd7;
    tick();
    chk("oor_err2", {31'h0, c_err}, 32'h1);
    check_all("oor2");
    we = 1'b0;
    tick();
    chk("oor_err3", {31'h0, c_err}, 32'h0);
    chk("oor_rd6", c_rd0, 32'h0);
    chk("oor_rd7", c_rd1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      rd_addr0 = 3'(i);
      #0.5;
      chk("oor_unchanged", c_rd0, m_mem[2][i]);
    end
    check_all("oor_idle");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = $urandom;
      rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      rd_addr1 = 3'($urandom_range(0, 7));
      #1;
      check_all("rand_pre");
      tick();
      check_all("rand_post");
    end

    // Fill, then asynchronous reset 3 ns after an edge with a write pending.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wr_addr = 3'(i); wr_data = $urandom | 32'h1;
      tick();
    end
    rd_addr0 = 3'd2; rd_addr1 = 3'd5;
    we = 1'b1; wr_addr = 3'd2; wr_data = 32'h5a5a5a5a;
    #2;
    reset = 1'b1;
    model_clear();
    #0.5;
    chk("areset_rd2", a_rd0, 32'h0);
    chk("areset_rd5", a_rd1, 32'h0);
    check_all("areset");
    tick();
    check_all("areset_edge");
    #2 reset = 1'b0;
    we = 1'b1; wr_addr = 3'd1; wr_data = 32'h0badf00d; rd_addr0 = 3'd1; rd_addr1 = 3'd2;
    tick();
    we = 1'b0;
    #0.5;
    chk("post_reset_wr1", a_rd0, 32'h0badf00d);
    chk("post_reset_lost", a_rd1, 32'h0);
    check_all("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
